prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 24 ++
 rtl/prog_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - load-stream, CPU read port and status bundle for prog_loader
interface prog_loader_if;
   logic       load_start;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_end;
   logic       load_ready;
   logic [4:0] direccion;
   logic [7:0] prog;
   logic       cpu_hold;
   logic [5:0] words_loaded;
   logic       load_done;
   logic       load_error;

   modport master (
      output load_start, load_valid, load_data, load_end, direccion,
      input  load_ready, prog, cpu_hold, words_loaded, load_done, load_error
   );

   modport slave (
      input  load_start, load_valid, load_data, load_end, direccion,
      output load_ready, prog, cpu_hold, words_loaded, load_done, load_error
   );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - 32x8 program memory loader holding the CPU in reset while loading.
// Optional trailing checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader (
   input logic         clk,
   input logic         reset,
   prog_loader_if.slave bus
);
`ifdef PROG_LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
   localparam state_t END_STATE = CHECK;
`else
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   localparam state_t END_STATE = DONE;
`endif

   state_t     state, state_next;
   logic [7:0] mem [32];
   logic [5:0] words_loaded;
   logic       cpu_hold;
   logic       load_done;
   logic       restart;
   logic       wr_en;
   logic       load_ready;
   logic       xfer;
   logic [4:0] wr_ptr;

   // words_loaded never exceeds 32, so its low bits double as the write pointer
   assign wr_ptr = words_loaded[4:0];
`ifdef PROG_LOADER_CHECKSUM_EN
   assign load_ready = (state == LOAD) || (state == CHECK);
`else
   assign load_ready = (state == LOAD);
`endif
   assign xfer = bus.load_valid && load_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic chk_en;
`endif

   always_comb begin
      state_next = state;
      restart    = 1'b0;
      wr_en      = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_en     = 1'b0;
`endif
      case (state)
         IDLE, DONE: begin
            if (bus.load_start) begin
               state_next = LOAD;
               restart    = 1'b1;
            end
         end
         LOAD: begin
            if (bus.load_start) begin
               restart = 1'b1;
            end else begin
               wr_en = xfer;
               if (bus.load_end || (xfer && wr_ptr == 5'd31))
                  state_next = END_STATE;
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         CHECK: begin
            if (bus.load_start) begin
               restart = 1'b1;
               state_next = LOAD;
            end else if (xfer) begin
               chk_en     = 1'b1;
               state_next = DONE;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
         words_loaded <= 6'd0;
         cpu_hold     <= 1'b0;
         load_done    <= 1'b0;
      end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
         cpu_hold <= (state_next == LOAD) || (state_next == CHECK);
`else
         cpu_hold <= (state_next == LOAD);
`endif
         load_done <= (state_next == DONE);
         if (restart) begin
            words_loaded <= 6'd0;
         end else if (wr_en) begin
            mem[wr_ptr]  <= bus.load_data;
            words_loaded <= words_loaded + 6'd1;
         end
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] sum;
   logic       load_error;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum        <= 8'h00;
         load_error <= 1'b0;
      end else if (restart) begin
         sum        <= 8'h00;
         load_error <= 1'b0;
      end else if (wr_en) begin
         sum <= sum + bus.load_data;
      end else if (chk_en) begin
         load_error <= (bus.load_data != sum);
      end
   end

   assign bus.load_error = load_error;
`else
   assign bus.load_error = 1'b0;
`endif

   assign bus.load_ready   = load_ready;
   assign bus.prog         = mem[bus.direccion];
   assign bus.cpu_hold     = cpu_hold;
   assign bus.words_loaded = words_loaded;
   assign bus.load_done    = load_done;
endmodule
